// File: rtl/butterfly_dif_pipe.sv
// Pipelined radix-2 DIF (Gentleman-Sande) butterfly: a_o = a+b, b_o = (a-b)*tw.
// Three register stages that all advance together under one global stall.
module butterfly_dif_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] a_re_i,
    input  logic [DATA_WIDTH-1:0] a_im_i,
    input  logic [DATA_WIDTH-1:0] b_re_i,
    input  logic [DATA_WIDTH-1:0] b_im_i,
    input  logic [FRAC_BITS:0]    tw_re_i,
    input  logic [FRAC_BITS:0]    tw_im_i,
    input  logic                  inv_i,
    input  logic                  scale_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH:0]   a_re_o,
    output logic [DATA_WIDTH:0]   a_im_o,
    output logic [DATA_WIDTH:0]   b_re_o,
    output logic [DATA_WIDTH:0]   b_im_o,
    output logic                  ovf_o
);

    localparam int unsigned AW = DATA_WIDTH + 1;  // sum/diff/output width
    localparam int unsigned EW = AW + 1;          // a_o rounding headroom
    localparam int unsigned TW = FRAC_BITS + 2;   // twiddle width after optional negation
    localparam int unsigned PW = AW + TW;         // full product width
    localparam int unsigned RW = PW + 2;          // combine + rounding headroom

    localparam logic signed [RW-1:0] RND_HALF = RW'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [RW-1:0] SAT_MAX  = RW'((1 << (AW - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN  = -SAT_MAX - RW'(1);

    logic adv;

    // Stage 1 registers
    logic                 s1_valid_q, s1_valid_d;
    logic signed [AW-1:0] s1_sum_re_q, s1_sum_re_d;
    logic signed [AW-1:0] s1_sum_im_q, s1_sum_im_d;
    logic signed [AW-1:0] s1_diff_re_q, s1_diff_re_d;
    logic signed [AW-1:0] s1_diff_im_q, s1_diff_im_d;
    logic signed [TW-1:0] s1_tw_re_q, s1_tw_re_d;
    logic signed [TW-1:0] s1_tw_im_q, s1_tw_im_d;
    logic                 s1_scale_q, s1_scale_d;

    // Stage 2 registers
    logic                 s2_valid_q, s2_valid_d;
    logic signed [AW-1:0] s2_sum_re_q, s2_sum_re_d;
    logic signed [AW-1:0] s2_sum_im_q, s2_sum_im_d;
    logic signed [PW-1:0] s2_rr_q, s2_rr_d;
    logic signed [PW-1:0] s2_ii_q, s2_ii_d;
    logic signed [PW-1:0] s2_ri_q, s2_ri_d;
    logic signed [PW-1:0] s2_ir_q, s2_ir_d;
    logic                 s2_scale_q, s2_scale_d;

    // Stage 3 (output) registers
    logic                 s3_valid_q, s3_valid_d;
    logic signed [AW-1:0] s3_a_re_q, s3_a_re_d;
    logic signed [AW-1:0] s3_a_im_q, s3_a_im_d;
    logic signed [AW-1:0] s3_b_re_q, s3_b_re_d;
    logic signed [AW-1:0] s3_b_im_q, s3_b_im_d;
    logic                 s3_ovf_q, s3_ovf_d;

    // Stage 1 combinational
    logic signed [TW-1:0] tw_im_ext;

    // Stage 3 combinational
    logic signed [RW-1:0] re_full, im_full;
    logic signed [RW-1:0] re_biased, im_biased;
    logic signed [RW-1:0] re_rnd, im_rnd;
    logic signed [RW-1:0] bias;
    logic signed [AW-1:0] re_sat, im_sat;
    logic                 re_ovf, im_ovf;
    logic signed [EW-1:0] a_re_ext, a_im_ext;
    logic signed [AW-1:0] a_re_half, a_im_half;

    assign adv        = !s3_valid_q || out_ready_i;
    assign in_ready_o = adv;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sum_re_d  = s1_sum_re_q;
        s1_sum_im_d  = s1_sum_im_q;
        s1_diff_re_d = s1_diff_re_q;
        s1_diff_im_d = s1_diff_im_q;
        s1_tw_re_d   = s1_tw_re_q;
        s1_tw_im_d   = s1_tw_im_q;
        s1_scale_d   = s1_scale_q;
        // Extra bit so conjugating -1.0 yields an exact +1.0
        tw_im_ext    = TW'($signed(tw_im_i));
        if (adv) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_sum_re_d  = AW'($signed(a_re_i)) + AW'($signed(b_re_i));
                s1_sum_im_d  = AW'($signed(a_im_i)) + AW'($signed(b_im_i));
                s1_diff_re_d = AW'($signed(a_re_i)) - AW'($signed(b_re_i));
                s1_diff_im_d = AW'($signed(a_im_i)) - AW'($signed(b_im_i));
                s1_tw_re_d   = TW'($signed(tw_re_i));
                s1_tw_im_d   = inv_i ? -tw_im_ext : tw_im_ext;
                s1_scale_d   = scale_i;
            end
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_sum_re_d = s2_sum_re_q;
        s2_sum_im_d = s2_sum_im_q;
        s2_rr_d     = s2_rr_q;
        s2_ii_d     = s2_ii_q;
        s2_ri_d     = s2_ri_q;
        s2_ir_d     = s2_ir_q;
        s2_scale_d  = s2_scale_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_re_d = s1_sum_re_q;
                s2_sum_im_d = s1_sum_im_q;
                s2_rr_d     = PW'(s1_diff_re_q) * PW'(s1_tw_re_q);
                s2_ii_d     = PW'(s1_diff_im_q) * PW'(s1_tw_im_q);
                s2_ri_d     = PW'(s1_diff_re_q) * PW'(s1_tw_im_q);
                s2_ir_d     = PW'(s1_diff_im_q) * PW'(s1_tw_re_q);
                s2_scale_d  = s1_scale_q;
            end
        end
    end

    always_comb begin
        re_full   = RW'(s2_rr_q) - RW'(s2_ii_q);
        im_full   = RW'(s2_ri_q) + RW'(s2_ir_q);
        bias      = s2_scale_q ? (RND_HALF <<< 1) : RND_HALF;
        re_biased = re_full + bias;
        im_biased = im_full + bias;
        re_rnd    = s2_scale_q ? (re_biased >>> (FRAC_BITS + 1)) : (re_biased >>> FRAC_BITS);
        im_rnd    = s2_scale_q ? (im_biased >>> (FRAC_BITS + 1)) : (im_biased >>> FRAC_BITS);

        re_ovf = 1'b0;
        re_sat = AW'(re_rnd);
        if (re_rnd > SAT_MAX) begin
            re_ovf = 1'b1;
            re_sat = AW'(SAT_MAX);
        end else if (re_rnd < SAT_MIN) begin
            re_ovf = 1'b1;
            re_sat = AW'(SAT_MIN);
        end

        im_ovf = 1'b0;
        im_sat = AW'(im_rnd);
        if (im_rnd > SAT_MAX) begin
            im_ovf = 1'b1;
            im_sat = AW'(SAT_MAX);
        end else if (im_rnd < SAT_MIN) begin
            im_ovf = 1'b1;
            im_sat = AW'(SAT_MIN);
        end

        // Sum path has one spare bit, so halving can never overflow
        a_re_ext  = EW'(s2_sum_re_q) + EW'(1);
        a_im_ext  = EW'(s2_sum_im_q) + EW'(1);
        a_re_half = AW'(a_re_ext >>> 1);
        a_im_half = AW'(a_im_ext >>> 1);
    end

    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_a_re_d  = s3_a_re_q;
        s3_a_im_d  = s3_a_im_q;
        s3_b_re_d  = s3_b_re_q;
        s3_b_im_d  = s3_b_im_q;
        s3_ovf_d   = s3_ovf_q;
        if (adv) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_a_re_d = s2_scale_q ? a_re_half : s2_sum_re_q;
                s3_a_im_d = s2_scale_q ? a_im_half : s2_sum_im_q;
                s3_b_re_d = re_sat;
                s3_b_im_d = im_sat;
                s3_ovf_d  = re_ovf || im_ovf;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q   <= 1'b0;
            s1_sum_re_q  <= '0;
            s1_sum_im_q  <= '0;
            s1_diff_re_q <= '0;
            s1_diff_im_q <= '0;
            s1_tw_re_q   <= '0;
            s1_tw_im_q   <= '0;
            s1_scale_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_sum_re_q  <= '0;
            s2_sum_im_q  <= '0;
            s2_rr_q      <= '0;
            s2_ii_q      <= '0;
            s2_ri_q      <= '0;
            s2_ir_q      <= '0;
            s2_scale_q   <= 1'b0;
            s3_valid_q   <= 1'b0;
            s3_a_re_q    <= '0;
            s3_a_im_q    <= '0;
            s3_b_re_q    <= '0;
            s3_b_im_q    <= '0;
            s3_ovf_q     <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sum_re_q  <= s1_sum_re_d;
            s1_sum_im_q  <= s1_sum_im_d;
            s1_diff_re_q <= s1_diff_re_d;
            s1_diff_im_q <= s1_diff_im_d;
            s1_tw_re_q   <= s1_tw_re_d;
            s1_tw_im_q   <= s1_tw_im_d;
            s1_scale_q   <= s1_scale_d;
            s2_valid_q   <= s2_valid_d;
            s2_sum_re_q  <= s2_sum_re_d;
            s2_sum_im_q  <= s2_sum_im_d;
            s2_rr_q      <= s2_rr_d;
            s2_ii_q      <= s2_ii_d;
            s2_ri_q      <= s2_ri_d;
            s2_ir_q      <= s2_ir_d;
            s2_scale_q   <= s2_scale_d;
            s3_valid_q   <= s3_valid_d;
            s3_a_re_q    <= s3_a_re_d;
            s3_a_im_q    <= s3_a_im_d;
            s3_b_re_q    <= s3_b_re_d;
            s3_b_im_q    <= s3_b_im_d;
            s3_ovf_q     <= s3_ovf_d;
        end
    end

    assign out_valid_o = s3_valid_q;
    assign a_re_o      = s3_a_re_q;
    assign a_im_o      = s3_a_im_q;
    assign b_re_o      = s3_b_re_q;
    assign b_im_o      = s3_b_im_q;
    assign ovf_o       = s3_ovf_q;

endmodule

// File: tb/tb_butterfly_dif_pipe.sv
// Bench for butterfly_dif_pipe: vector table, scoreboard queue, stall/reset/latency sequences
// and a randomized backpressure run checked against an integer reference model.
module tb_butterfly_dif_pipe;

    localparam int DW = 16;
    localparam int FB = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, inv, scale, out_valid, out_ready, ovf;
    logic [DW-1:0] a_re, a_im, b_re, b_im;
    logic [FB:0]   tw_re, tw_im;
    logic [DW:0]   a_re_o, a_im_o, b_re_o, b_im_o;

    always #5 clk = ~clk;

    butterfly_dif_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im),
        .tw_re_i(tw_re), .tw_im_i(tw_im), .inv_i(inv), .scale_i(scale),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .a_re_o(a_re_o), .a_im_o(a_im_o), .b_re_o(b_re_o), .b_im_o(b_im_o),
        .ovf_o(ovf)
    );

    typedef struct {
        int a_re; int a_im; int b_re; int b_im; int tw_re; int tw_im; bit inv; bit scale;
        int ea_re; int ea_im; int eb_re; int eb_im; bit eovf;
    } vec_t;

    vec_t        q[$];
    vec_t        cur;
    vec_t        tbl[11];
    vec_t        sb[5];
    bit          accepted;
    bit          bp_en;
    bit          prev_hold;
    logic [DW:0] held[4];
    logic        held_ovf;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic int sx(logic [DW:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clamp(longint x, ref bit o);
        if (x > 65535) begin o = 1'b1; return 65535; end
        if (x < -65536) begin o = 1'b1; return -65536; end
        return int'(x);
    endfunction

    // Integer reference: exact products, half-up rounding by floor, clamp to 17 bits
    function automatic vec_t model(int ar, int ai, int br, int bi, int twr, int twi,
                                   bit iv, bit sc);
        vec_t   v;
        longint dr, di, ti, re, im, half;
        int     sh, sr, si;
        bit     o;
        v = '{ar, ai, br, bi, twr, twi, iv, sc, 0, 0, 0, 0, 1'b0};
        dr = longint'(ar) - longint'(br);
        di = longint'(ai) - longint'(bi);
        ti = iv ? -longint'(twi) : longint'(twi);
        re = dr * longint'(twr) - di * ti;
        im = dr * ti + di * longint'(twr);
        sh = FB + int'(sc);
        half = longint'(1) << (sh - 1);
        o = 1'b0;
        v.eb_re = clamp((re + half) >>> sh, o);
        v.eb_im = clamp((im + half) >>> sh, o);
        v.eovf = o;
        sr = ar + br;
        si = ai + bi;
        v.ea_re = sc ? ((sr + 1) >>> 1) : sr;
        v.ea_im = sc ? ((si + 1) >>> 1) : si;
        return v;
    endfunction

    task automatic check(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic apply(vec_t v);
        a_re = v.a_re[DW-1:0];
        a_im = v.a_im[DW-1:0];
        b_re = v.b_re[DW-1:0];
        b_im = v.b_im[DW-1:0];
        tw_re = v.tw_re[FB:0];
        tw_im = v.tw_im[FB:0];
        inv = v.inv;
        scale = v.scale;
        cur = v;
    endtask

    task automatic monitor();
        vec_t e;
        if (rst) begin
            prev_hold = 1'b0;
            return;
        end
        if (prev_hold) begin
            n_checks++;
            if (!out_valid || a_re_o !== held[0] || a_im_o !== held[1] || b_re_o !== held[2]
                || b_im_o !== held[3] || ovf !== held_ovf) begin
                n_fail++;
                $display("FAIL hold: got v=%0b a=(%0d,%0d) b=(%0d,%0d) ovf=%0b, held a=(%0d,%0d) b=(%0d,%0d) ovf=%0b",
                         out_valid, sx(a_re_o), sx(a_im_o), sx(b_re_o), sx(b_im_o), ovf,
                         sx(held[0]), sx(held[1]), sx(held[2]), sx(held[3]), held_ovf);
            end
        end
        if (out_valid && out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious beat: got a=(%0d,%0d) b=(%0d,%0d), expected no output",
                         sx(a_re_o), sx(a_im_o), sx(b_re_o), sx(b_im_o));
            end else begin
                e = q.pop_front();
                if (sx(a_re_o) != e.ea_re || sx(a_im_o) != e.ea_im || sx(b_re_o) != e.eb_re
                    || sx(b_im_o) != e.eb_im || ovf != e.eovf) begin
                    n_fail++;
                    $display("FAIL beat: got a=(%0d,%0d) b=(%0d,%0d) ovf=%0b, expected a=(%0d,%0d) b=(%0d,%0d) ovf=%0b",
                             sx(a_re_o), sx(a_im_o), sx(b_re_o), sx(b_im_o), ovf,
                             e.ea_re, e.ea_im, e.eb_re, e.eb_im, e.eovf);
                end
            end
        end
        prev_hold = out_valid && !out_ready;
        held[0] = a_re_o;
        held[1] = a_im_o;
        held[2] = b_re_o;
        held[3] = b_im_o;
        held_ovf = ovf;
    endtask

    // Called at posedge+1; returns at the next posedge+1
    task automatic tick();
        @(negedge clk);
        accepted = !rst && in_valid && in_ready;
        if (accepted) q.push_back(cur);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(vec_t v);
        apply(v);
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (accepted) return;
        end
        check("accept timeout", 0, 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain leftover beats", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, k, seen, gap;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        bp_en = 1'b0;
        prev_hold = 1'b0;
        apply('{0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset a_re_o", sx(a_re_o), 0);
        check("reset b_im_o", sx(b_im_o), 0);
        check("reset ovf", ovf, 0);
        @(posedge clk);
        #1;

        tbl[0]  = '{1000, 200, 600, -100, 32767, 0, 0, 0, 1600, 100, 400, 300, 0};
        tbl[1]  = '{1000, 200, 600, -100, 0, -32768, 0, 0, 1600, 100, 300, -400, 0};
        tbl[2]  = '{1000, 200, 600, -100, 0, -32768, 1, 0, 1600, 100, -300, 400, 0};
        tbl[3]  = '{1000, 200, 600, -100, 32767, 0, 0, 1, 800, 50, 200, 150, 0};
        tbl[4]  = '{-32768, -32768, 32767, 32767, 32767, 32767, 0, 0, -1, -1, 0, -65536, 1};
        tbl[5]  = '{32767, -32768, -32768, 32767, 32767, 32767, 0, 0, -1, -1, 65535, 0, 1};
        tbl[6]  = '{32767, -32768, -32768, 32767, 32767, 32767, 0, 1, 0, 0, 65533, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 16384, 0, 0, 0, 1, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 1, 0, 16384, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[9]  = '{-3, 3, 0, 0, 0, 0, 0, 1, -1, 2, 0, 0, 0};
        tbl[10] = '{100, 0, -100, 0, -32768, 0, 0, 0, 0, 0, -200, 0, 0};

        // Latency: one beat into an empty pipe appears after exactly 3 edges
        send(tbl[0]);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", lat, 3);
        drain();

        // Back-to-back vector table at full rate
        for (int i = 0; i < 11; i++) send(tbl[i]);
        drain();

        // Stall with 5 pending beats: only 3 fit, then all emerge in order
        for (int i = 0; i < 5; i++)
            sb[i] = model(100 * (i + 1), -50 * i, 30 * i, 7, 32767 - 1000 * i, 5000 * i,
                          1'(i % 2), 1'(i / 3));
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            apply(sb[k < 5 ? k : 4]);
            in_valid = 1'b1;
            check("stall in_ready", in_ready, (c < 3) ? 1 : 0);
            tick();
            if (accepted) k++;
        end
        check("stall accepted count", k, 3);
        for (int j = 3; j < 5; j++) send(sb[j]);
        drain();

        // Reset with two beats in flight: both are dropped
        send(tbl[1]);
        send(tbl[2]);
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        check("pre-reset out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid-reset out_valid", out_valid, 0);
        q.delete();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post-reset in_ready", in_ready, 1);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("dropped beats reappeared", seen, 0);

        // Random operands with random backpressure and input gaps
        bp_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(model(int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
            gap = int'($urandom_range(0, 3));
            if (gap == 0) begin
                in_valid = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        bp_en = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
